// File: rtl/iter_alu.sv
// Registered execute-stage ALU with valid/ready handshake and NZCV flags.
// Define ITER_ALU_MUL_EN to add the iterative shift-add multiplier (op 1000).
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             out_err
);

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                           OP_ORR = 4'b0011, OP_EOR = 4'b0100, OP_ADC = 4'b0101,
                           OP_BIC = 4'b0110, OP_SBC = 4'b0111;

    if (WIDTH < 4 || CNT_W < $clog2(WIDTH) + 1) begin : g_param_chk
        $error("iter_alu: WIDTH must be >= 4 and CNT_W must hold WIDTH-1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic             accept, arith, legal, cin;
    logic [WIDTH-1:0] bc, alu_res;
    logic [WIDTH:0]   sum;
    logic [3:0]       alu_flags;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        bc = (op == OP_SUB || op == OP_SBC) ? ~src_b : src_b;
        case (op)
            OP_SUB:         cin = 1'b1;
            OP_ADC, OP_SBC: cin = carry_in;
            default:        cin = 1'b0;
        endcase
        sum     = {1'b0, src_a} + {1'b0, bc} + {{WIDTH{1'b0}}, cin};
        arith   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
        legal   = 1'b1;
        alu_res = '0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: alu_res = sum[WIDTH-1:0];
            OP_AND:  alu_res = src_a & src_b;
            OP_ORR:  alu_res = src_a | src_b;
            OP_EOR:  alu_res = src_a ^ src_b;
            OP_BIC:  alu_res = src_a & ~src_b;
            default: legal = 1'b0;
        endcase
        // Illegal ops leave alu_res at zero, so only Z can be set.
        alu_flags = {alu_res[WIDTH-1], alu_res == '0, arith & sum[WIDTH],
                     arith && (src_a[WIDTH-1] == bc[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1])};
    end

`ifdef ITER_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
    logic [CNT_W-1:0] cnt;
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= 4'b0;
            out_err   <= 1'b0;
`ifdef ITER_ALU_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
`ifdef ITER_ALU_MUL_EN
                        if (op == OP_MUL) begin
                            mcand     <= src_a;
                            mplier    <= src_b;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= BUSY;
                            out_valid <= 1'b0;
                        end else
`endif
                        begin
                            result    <= alu_res;
                            flags     <= alu_flags;
                            out_err   <= ~legal;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
`ifdef ITER_ALU_MUL_EN
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result    <= acc_nxt;
                        flags     <= {acc_nxt[WIDTH-1], acc_nxt == '0, 2'b00};
                        out_err   <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
